cell_pos_pingpong: RTL and testbench
====================================

Name: cell_pos_pingpong

Overview:
- Parametrised, double-buffered successor to the single-port per-cell position RAM.
- Holds two banks of packed particle positions, {posz, posy, posx}, for one cell.
  - The read bank serves the force-evaluation pipeline.
  - The write bank is filled in parallel by motion update and cell migration.
- A single-cycle swap exchanges the banks at the timestep boundary.
- The particle count is kept in registers, not at address 0, so every address is a particle slot.

Parameters:
- DATA_WIDTH, 96, packed position word width ({posz, posy, posx}, 32 bits each).
- DEPTH, 220, max particles per bank.
- ADDR_WIDTH, 8, address width; must satisfy 2^ADDR_WIDTH >= DEPTH.
- INIT_COUNT, 0, read-bank particle count after reset. Bank 0 is preloaded by the memory init file.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  particle index in the read bank.
- rd_valid  out  1  rd_data is valid this cycle.
- rd_data  out  DATA_WIDTH  read position word.
- rd_count  out  ADDR_WIDTH+1  number of particles in the read bank.
- wr_en  in  1  append one particle to the write bank.
- wr_data  in  DATA_WIDTH  position word to append.
- wr_count  out  ADDR_WIDTH+1  number of particles written so far.
- wr_full  out  1  wr_count == DEPTH.
- wr_overflow  out  1  sticky; set when an append was dropped.
- swap_req  in  1  single-cycle pulse that exchanges the banks.
- rd_bank  out  1  index of the bank currently being read (0/1).

Behaviour:
- Reset, synchronous, active-high:
  - rd_bank=0, rd_count=INIT_COUNT, wr_count=0, wr_full=0, wr_overflow=0.
  - rd_valid=0, rd_data=0, and the read pipeline is flushed.
  - Memory contents are not cleared.
  - rst overrides every other input in the same cycle.
- Read pipeline, fixed 2-cycle latency:
  - rd_en at edge N gives rd_valid=1 and rd_data at edge N+2.
  - One read can be accepted per cycle, back-to-back, with no stall.
  - The bank is selected from rd_bank as sampled at edge N, so reads in flight across a swap return old-bank data.
  - If rd_addr >= rd_count at issue, rd_data=0 (force-to-zero null particle) but rd_valid is still 1.
  - When rd_valid=0, rd_data is held at 0.
- Append write:
  - On wr_en with !wr_full: the word is written to address wr_count of bank ~rd_bank, and wr_count increments next cycle.
  - On wr_en with wr_full: the write is dropped, wr_count is unchanged, and wr_overflow is set to 1.
  - wr_full is combinational from wr_count.
- Swap (swap_req=1 at edge N):
  - rd_bank toggles.
  - rd_count gets wr_count, plus 1 if an accepted append happens in the same cycle.
  - wr_count=0 and wr_overflow=0.
  - A simultaneous accepted append lands in the old write bank and is counted in the new rd_count.
  - A simultaneous dropped append (write bank full) still sets nothing; wr_overflow ends at 0.
  - Back-to-back swaps are legal. The second swap makes the previous read bank (now holding stale data) the read bank with rd_count=0.
- Read/write collision: the two banks are always distinct, so there are no read-during-write hazards on the same bank.
- Memory:
  - Two simple-dual-port RAMs of DEPTH x DATA_WIDTH, or one of 2*DEPTH with the bank as the address MSB.
  - Registered output, M20K-targetable.
  - Bank 0 init file is cell_ini_file_<cell>.hex, selected by the same path defines as the existing cell modules.
- Widths: counts are ADDR_WIDTH+1 bits so that DEPTH is representable; counts never exceed DEPTH.

Test Plan:
- Reset with INIT_COUNT=5 and bank 0 preloaded, then rd_en for addr 0..6 on consecutive cycles → rd_valid from cycle+2, five preloaded words in order, then two zero words; rd_count=5.
- Append 3 words (A,B,C), pulse swap_req, read addr 0..2 → rd_bank=1, rd_count=3, data A,B,C; wr_count=0.
- With DEPTH=4, append 5 words → wr_full=1 after the 4th, 5th dropped, wr_overflow=1, wr_count=4. Then swap → wr_overflow=0, rd_count=4.
- rd_en at edge N and swap_req at edge N (and N+1) → data for reads issued at N comes from the old bank; reads issued at N+1 come from the new bank.
- wr_en and swap_req in the same cycle with wr_count=2 → new rd_count=3, and the appended word is readable at addr 2.
- Assert rst during a pending read stream and with wr_count=3 → next cycle rd_valid=0, rd_data=0, wr_count=0, rd_bank=0, rd_count=INIT_COUNT; no stale rd_valid appears afterwards.

Source files
------------

// File: rtl/cell_pos_pingpong.sv
// Double-buffered per-cell particle position store: one bank feeds the force pipeline while the
// other is appended to by motion update / migration; a swap pulse exchanges them.
module cell_pos_pingpong #(
  parameter int unsigned DATA_WIDTH = 96,
  parameter int unsigned DEPTH      = 220,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned INIT_COUNT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH:0]   rd_count,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  wr_full,
  output logic                  wr_overflow,
  input  logic                  swap_req,
  output logic                  rd_bank
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  typedef logic [CntW-1:0] cnt_t;

  // Bank control state
  logic rd_bank_q, rd_bank_d;
  cnt_t rd_count_q, rd_count_d;
  cnt_t wr_count_q, wr_count_d;
  logic wr_ovf_q, wr_ovf_d;

  // Read pipeline: issue -> RAM register -> RAM output register -> gated output
  logic s1_valid_q, s1_valid_d;
  logic s1_null_q, s1_null_d;
  logic s1_bank_q, s1_bank_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_null_q, s2_null_d;
  logic rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  logic [DATA_WIDTH-1:0] bank0_mem [DEPTH];
  logic [DATA_WIDTH-1:0] bank1_mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram0_q, ram1_q, ram_out_q;

  logic                  full;
  logic                  wr_accept;
  logic                  wr_bank0, wr_bank1;
  logic [ADDR_WIDTH-1:0] wr_addr;

  always_comb begin
    full      = (wr_count_q == cnt_t'(DEPTH));
    wr_accept = wr_en && !full && !rst;
    // The write bank is always the one not being read.
    wr_bank0  = wr_accept && rd_bank_q;
    wr_bank1  = wr_accept && !rd_bank_q;
    wr_addr   = wr_count_q[ADDR_WIDTH-1:0];

    rd_bank_d  = rd_bank_q;
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q + cnt_t'(wr_accept);
    wr_ovf_d   = wr_ovf_q | (wr_en & full);
    if (swap_req) begin
      rd_bank_d  = ~rd_bank_q;
      rd_count_d = wr_count_q + cnt_t'(wr_accept);
      wr_count_d = '0;
      wr_ovf_d   = 1'b0;
    end

    s1_valid_d = rd_en;
    s1_null_d  = ({1'b0, rd_addr} >= rd_count_q);
    s1_bank_d  = rd_bank_q;
    s2_valid_d = s1_valid_q;
    s2_null_d  = s1_null_q;
    rd_valid_d = s2_valid_q;
    rd_data_d  = (s2_valid_q && !s2_null_q) ? ram_out_q : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bank_q  <= 1'b0;
      rd_count_q <= cnt_t'(INIT_COUNT);
      wr_count_q <= '0;
      wr_ovf_q   <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_null_q  <= 1'b0;
      s1_bank_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_null_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_bank_q  <= rd_bank_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      wr_ovf_q   <= wr_ovf_d;
      s1_valid_q <= s1_valid_d;
      s1_null_q  <= s1_null_d;
      s1_bank_q  <= s1_bank_d;
      s2_valid_q <= s2_valid_d;
      s2_null_q  <= s2_null_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Plain simple-dual-port RAM per bank, no reset on storage so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_bank0) begin
      bank0_mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      ram0_q <= bank0_mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_bank1) begin
      bank1_mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      ram1_q <= bank1_mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    ram_out_q <= s1_bank_q ? ram1_q : ram0_q;
  end

  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign rd_count    = rd_count_q;
  assign wr_count    = wr_count_q;
  assign wr_full     = full;
  assign wr_overflow = wr_ovf_q;
  assign rd_bank     = rd_bank_q;

endmodule

// File: tb/tb_cell_pos_pingpong.sv
// Bench for cell_pos_pingpong: a 220-deep instance and a 4-deep instance, both tracked by a
// bank/count model with a two-edge response queue, plus directed literal checks.
module tb_cell_pos_pingpong;

  logic clk;
  int   total = 0;
  int   bad   = 0;

  // Main instance (DEPTH 220, INIT_COUNT 5)
  logic        m_rst, m_rd_en, m_wr_en, m_swap;
  logic [7:0]  m_rd_addr;
  logic [95:0] m_wr_data;
  logic        m_rd_valid, m_wr_full, m_wr_overflow, m_rd_bank;
  logic [95:0] m_rd_data;
  logic [8:0]  m_rd_count, m_wr_count;

  // Small instance (DEPTH 4, INIT_COUNT 0)
  logic        s_rst, s_rd_en, s_wr_en, s_swap;
  logic [1:0]  s_rd_addr;
  logic [95:0] s_wr_data;
  logic        s_rd_valid, s_wr_full, s_wr_overflow, s_rd_bank;
  logic [95:0] s_rd_data;
  logic [2:0]  s_rd_count, s_wr_count;

  cell_pos_pingpong #(
    .DATA_WIDTH(96), .DEPTH(220), .ADDR_WIDTH(8), .INIT_COUNT(5)
  ) u_main (
    .clk(clk), .rst(m_rst), .rd_en(m_rd_en), .rd_addr(m_rd_addr), .rd_valid(m_rd_valid),
    .rd_data(m_rd_data), .rd_count(m_rd_count), .wr_en(m_wr_en), .wr_data(m_wr_data),
    .wr_count(m_wr_count), .wr_full(m_wr_full), .wr_overflow(m_wr_overflow),
    .swap_req(m_swap), .rd_bank(m_rd_bank)
  );

  cell_pos_pingpong #(
    .DATA_WIDTH(96), .DEPTH(4), .ADDR_WIDTH(2), .INIT_COUNT(0)
  ) u_small (
    .clk(clk), .rst(s_rst), .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_valid(s_rd_valid),
    .rd_data(s_rd_data), .rd_count(s_rd_count), .wr_en(s_wr_en), .wr_data(s_wr_data),
    .wr_count(s_wr_count), .wr_full(s_wr_full), .wr_overflow(s_wr_overflow),
    .swap_req(s_swap), .rd_bank(s_rd_bank)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [95:0] word(input int tag, input int k);
    return {32'(tag), 32'(k), 32'hC0DE_0000 + 32'(k)};
  endfunction

  // ---------------- Model ----------------
  typedef struct packed {
    bit        v;
    bit [95:0] d;
  } rsp_t;

  bit [95:0] mb [2][2][256];
  int        md_bank [2];
  int        md_rdcnt[2];
  int        md_wrcnt[2];
  bit        md_ovf  [2];
  bit        e_v     [2];
  bit [95:0] e_d     [2];
  rsp_t      q0[$];
  rsp_t      q1[$];

  function automatic void step(input int i, input bit r, input bit re, input int ra,
                               input bit we, input bit [95:0] wd, input bit sw);
    rsp_t n, z, o;
    bit   acc;
    int   dep;
    dep = (i == 0) ? 220 : 4;
    z   = '0;
    if (r) begin
      md_bank[i]  = 0;
      md_rdcnt[i] = (i == 0) ? 5 : 0;
      md_wrcnt[i] = 0;
      md_ovf[i]   = 1'b0;
      if (i == 0) begin q0 = {}; q0.push_back(z); q0.push_back(z); end
      else        begin q1 = {}; q1.push_back(z); q1.push_back(z); end
      e_v[i] = 1'b0;
      e_d[i] = '0;
      return;
    end
    n.v = re;
    n.d = (re && ra < md_rdcnt[i]) ? mb[i][md_bank[i]][ra] : '0;
    acc = we && (md_wrcnt[i] < dep);
    if (acc) begin
      mb[i][1 - md_bank[i]][md_wrcnt[i]] = wd;
      md_wrcnt[i]++;
    end else if (we) begin
      md_ovf[i] = 1'b1;
    end
    if (sw) begin
      md_bank[i]  = 1 - md_bank[i];
      md_rdcnt[i] = md_wrcnt[i];
      md_wrcnt[i] = 0;
      md_ovf[i]   = 1'b0;
    end
    if (i == 0) begin q0.push_back(n); o = q0.pop_front(); end
    else        begin q1.push_back(n); o = q1.pop_front(); end
    e_v[i] = o.v;
    e_d[i] = o.d;
  endfunction

  always @(posedge clk) begin
    step(0, m_rst, m_rd_en, int'(m_rd_addr), m_wr_en, m_wr_data, m_swap);
    step(1, s_rst, s_rd_en, int'(s_rd_addr), s_wr_en, s_wr_data, s_swap);
  end

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    chk("m.rd_valid", 96'(m_rd_valid), 96'(e_v[0]));
    chk("m.rd_data", m_rd_data, e_d[0]);
    chk("m.rd_count", 96'(m_rd_count), 96'(md_rdcnt[0]));
    chk("m.wr_count", 96'(m_wr_count), 96'(md_wrcnt[0]));
    chk("m.wr_full", 96'(m_wr_full), 96'(md_wrcnt[0] == 220));
    chk("m.wr_overflow", 96'(m_wr_overflow), 96'(md_ovf[0]));
    chk("m.rd_bank", 96'(m_rd_bank), 96'(md_bank[0]));
    chk("s.rd_valid", 96'(s_rd_valid), 96'(e_v[1]));
    chk("s.rd_data", s_rd_data, e_d[1]);
    chk("s.rd_count", 96'(s_rd_count), 96'(md_rdcnt[1]));
    chk("s.wr_count", 96'(s_wr_count), 96'(md_wrcnt[1]));
    chk("s.wr_full", 96'(s_wr_full), 96'(md_wrcnt[1] == 4));
    chk("s.wr_overflow", 96'(s_wr_overflow), 96'(md_ovf[1]));
    chk("s.rd_bank", 96'(s_rd_bank), 96'(md_bank[1]));
  end

  // ---------------- Stimulus ----------------
  // Apply one cycle of inputs, return at the following negedge with inputs idled.
  task automatic m_drive(input bit r, input bit re, input int ra, input bit we,
                         input logic [95:0] wd, input bit sw);
    m_rst = r; m_rd_en = re; m_rd_addr = 8'(ra); m_wr_en = we; m_wr_data = wd; m_swap = sw;
    @(negedge clk);
    m_rst = 0; m_rd_en = 0; m_rd_addr = '0; m_wr_en = 0; m_wr_data = '0; m_swap = 0;
  endtask

  task automatic s_drive(input bit r, input bit re, input int ra, input bit we,
                         input logic [95:0] wd, input bit sw);
    s_rst = r; s_rd_en = re; s_rd_addr = 2'(ra); s_wr_en = we; s_wr_data = wd; s_swap = sw;
    @(negedge clk);
    s_rst = 0; s_rd_en = 0; s_rd_addr = '0; s_wr_en = 0; s_wr_data = '0; s_swap = 0;
  endtask

  task automatic m_data(input string nm, input logic [95:0] exp);
    chk({nm, ".valid"}, 96'(m_rd_valid), 96'd1);
    chk({nm, ".data"}, m_rd_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_rst = 1; m_rd_en = 0; m_rd_addr = '0; m_wr_en = 0; m_wr_data = '0; m_swap = 0;
    s_rst = 1; s_rd_en = 0; s_rd_addr = '0; s_wr_en = 0; s_wr_data = '0; s_swap = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.rd_bank", 96'(m_rd_bank), 96'd0);
    chk("rst.rd_count", 96'(m_rd_count), 96'd5);
    chk("rst.wr_count", 96'(m_wr_count), 96'd0);
    chk("rst.rd_valid", 96'(m_rd_valid), 96'd0);
    chk("rst.rd_data", m_rd_data, 96'd0);
    m_rst = 0;
    s_rst = 0;

    // Preload bank 0 via the write path, then reset (memory survives reset).
    m_drive(0, 0, 0, 0, '0, 1);
    chk("pre.rd_bank", 96'(m_rd_bank), 96'd1);
    for (int k = 0; k < 5; k++) m_drive(0, 0, 0, 1, word(1, k), 0);
    chk("pre.wr_count", 96'(m_wr_count), 96'd5);
    m_drive(1, 0, 0, 0, '0, 0);
    chk("pre.rst_count", 96'(m_rd_count), 96'd5);

    // Read 0..6: five preloaded words, then two null particles.
    for (int c = 0; c < 9; c++) begin
      m_drive(0, c < 7, c, 0, '0, 0);
      if (c == 1) chk("pre.fill_valid", 96'(m_rd_valid), 96'd0);
      if (c >= 2) m_data("pre.rd", (c - 2 < 5) ? word(1, c - 2) : 96'd0);
    end

    // Append A,B,C then swap and read them back.
    for (int k = 0; k < 3; k++) m_drive(0, 0, 0, 1, word(2, k), 0);
    chk("abc.wr_count", 96'(m_wr_count), 96'd3);
    m_drive(0, 0, 0, 0, '0, 1);
    chk("abc.rd_bank", 96'(m_rd_bank), 96'd1);
    chk("abc.rd_count", 96'(m_rd_count), 96'd3);
    chk("abc.wr_count0", 96'(m_wr_count), 96'd0);
    for (int c = 0; c < 5; c++) begin
      m_drive(0, c < 3, c, 0, '0, 0);
      if (c >= 2) m_data("abc.rd", word(2, c - 2));
    end

    // Reads across back-to-back swaps: old bank, then new bank, then empty stale bank.
    m_drive(0, 0, 0, 1, word(2, 3), 0);
    m_drive(0, 0, 0, 1, word(2, 4), 0);
    chk("sw.wr_count", 96'(m_wr_count), 96'd2);
    m_drive(0, 1, 0, 0, '0, 1);
    m_drive(0, 1, 0, 0, '0, 1);
    chk("sw.rd_bank", 96'(m_rd_bank), 96'd1);
    chk("sw.rd_count", 96'(m_rd_count), 96'd0);
    m_drive(0, 1, 0, 0, '0, 0);
    m_data("sw.old", word(2, 0));
    m_drive(0, 0, 0, 0, '0, 0);
    m_data("sw.new", word(2, 3));
    m_drive(0, 0, 0, 0, '0, 0);
    m_data("sw.stale", 96'd0);

    // Append coinciding with swap at wr_count=2.
    m_drive(0, 0, 0, 1, word(2, 5), 0);
    m_drive(0, 0, 0, 1, word(2, 6), 0);
    m_drive(0, 0, 0, 1, word(2, 7), 1);
    chk("ws.rd_bank", 96'(m_rd_bank), 96'd0);
    chk("ws.rd_count", 96'(m_rd_count), 96'd3);
    chk("ws.wr_count", 96'(m_wr_count), 96'd0);
    m_drive(0, 1, 2, 0, '0, 0);
    m_drive(0, 1, 0, 0, '0, 0);
    m_drive(0, 0, 0, 0, '0, 0);
    m_data("ws.addr2", word(2, 7));
    m_drive(0, 0, 0, 0, '0, 0);
    m_data("ws.addr0", word(2, 5));

    // Reset with reads in flight and wr_count=3; reset overrides all inputs.
    for (int k = 8; k < 11; k++) m_drive(0, 0, 0, 1, word(2, k), 0);
    chk("rr.wr_count", 96'(m_wr_count), 96'd3);
    m_drive(0, 1, 0, 0, '0, 0);
    m_drive(0, 1, 1, 0, '0, 0);
    m_drive(1, 1, 2, 1, word(2, 11), 1);
    chk("rr.rd_valid", 96'(m_rd_valid), 96'd0);
    chk("rr.rd_data", m_rd_data, 96'd0);
    chk("rr.wr_count", 96'(m_wr_count), 96'd0);
    chk("rr.rd_bank", 96'(m_rd_bank), 96'd0);
    chk("rr.rd_count", 96'(m_rd_count), 96'd5);
    for (int c = 0; c < 4; c++) begin
      m_drive(0, 0, 0, 0, '0, 0);
      chk("rr.no_stale", 96'(m_rd_valid), 96'd0);
    end

    // Small instance: fill to DEPTH, overflow, swap.
    for (int k = 0; k < 5; k++) begin
      s_drive(0, 0, 0, 1, word(3, k), 0);
      if (k == 2) chk("ov.not_full", 96'(s_wr_full), 96'd0);
      if (k == 3) begin
        chk("ov.full", 96'(s_wr_full), 96'd1);
        chk("ov.count4", 96'(s_wr_count), 96'd4);
        chk("ov.no_ovf", 96'(s_wr_overflow), 96'd0);
      end
    end
    chk("ov.ovf", 96'(s_wr_overflow), 96'd1);
    chk("ov.count", 96'(s_wr_count), 96'd4);
    s_drive(0, 0, 0, 0, '0, 1);
    chk("ov.swap_ovf", 96'(s_wr_overflow), 96'd0);
    chk("ov.swap_rdcnt", 96'(s_rd_count), 96'd4);
    chk("ov.swap_bank", 96'(s_rd_bank), 96'd1);
    s_drive(0, 1, 3, 0, '0, 0);
    s_drive(0, 0, 0, 0, '0, 0);
    s_drive(0, 0, 0, 0, '0, 0);
    chk("ov.rd3", s_rd_data, word(3, 3));

    // Dropped append in the swap cycle does not count and leaves no overflow.
    for (int k = 0; k < 4; k++) s_drive(0, 0, 0, 1, word(4, k), 0);
    s_drive(0, 0, 0, 1, word(4, 9), 1);
    chk("ds.rd_count", 96'(s_rd_count), 96'd4);
    chk("ds.ovf", 96'(s_wr_overflow), 96'd0);
    chk("ds.rd_bank", 96'(s_rd_bank), 96'd0);
    s_drive(0, 1, 3, 0, '0, 0);
    s_drive(0, 0, 0, 0, '0, 0);
    s_drive(0, 0, 0, 0, '0, 0);
    chk("ds.rd3", s_rd_data, word(4, 3));
    s_drive(0, 0, 0, 0, '0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
